dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single-port 64x32 data memory between NUM_REQ requesters
//  (e.g. core load/store unit, DMA engine, debug port). Accepts one access per cycle and drives
//  the memory command bus from registers. Tags each read so the returned word reaches only its issuer.
//  Supports an optional bounded burst lock.
// PARAMETERS
//  NUM_REQ    2   number of requesters, legal range 2..4
//  MAX_BURST  4   max consecutive grants a locking requester may hold, >=1
//  ADDR_W     6   memory word-address width (package constant)
//  DATA_W     32  memory data width (package constant)
// PORTS
//  clk           in   1               system clock; all logic on posedge
//  rst           in   1               synchronous, active-high reset
//  req           in   NUM_REQ         access request; held until gnt
//  we            in   NUM_REQ         1=write, 0=read; qualified by req
//  lock          in   NUM_REQ         requester wants to keep the grant next cycle
//  addr          in   NUM_REQ*ADDR_W  packed word addresses, requester i at [i*ADDR_W +: ADDR_W]
//  wdata         in   NUM_REQ*DATA_W  packed write data
//  gnt           out  NUM_REQ         one-hot accept strobe; combinational, this cycle
//  rvalid        out  NUM_REQ         one-hot read-return strobe, registered
//  rdata         out  DATA_W          read data, valid when any rvalid bit is 1
//  mem_addr      out  ADDR_W          to memory addr, registered
//  mem_wdata     out  DATA_W          to memory write_data, registered
//  mem_read      out  1               to memory memread, registered
//  mem_write     out  1               to memory memwrite, registered
//  mem_rdata     in   DATA_W          from memory read_data
// BEHAVIOUR
//  - Reset values: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, rvalid=0.
//    Internal reset values: ptr=0, burst_cnt=0, lock_own=none.
//  - gnt: at most one bit set, and only for a requester with req=1.
//    Priority search starts at ptr and wraps modulo NUM_REQ.
//  - Lock override: if lock_own is valid and req[lock_own]=1, gnt goes to lock_own regardless of ptr.
//  - Accept at edge E0, when gnt[i]=1:
//    - mem_addr<=addr[i], mem_wdata<=wdata[i], mem_read<=~we[i], mem_write<=we[i].
//    - No grant: mem_read<=0, mem_write<=0; mem_addr and mem_wdata hold their values.
//  - Memory timing: write commits on the negedge between E0 and E1; read captured at E1.
//  - Read return: rvalid[i] is high for exactly the one cycle after E1 (2-cycle latency from accept).
//    rdata=mem_rdata (pass-through). Writes never raise rvalid.
//  - Tracking: a 1-deep read-tag register follows the mem command stage. Fully pipelined,
//    so one access per cycle is sustained with back-to-back rvalid.
//  - Hazards: a write accepted at E0 followed by a read of the same address at E1 returns the new data.
//    No stall or forwarding logic.
//  - Pointer and lock update, at each edge with gnt[i]=1:
//    - lock[i]=1 and burst_cnt<MAX_BURST-1: lock_own<=i, burst_cnt<=burst_cnt+1, ptr unchanged.
//    - otherwise: lock_own<=none, burst_cnt<=0, ptr<=(i+1) mod NUM_REQ.
//    - Burst cap: the MAX_BURST-th consecutive grant always releases the lock.
//  - Lock release: if the lock owner drops req, lock_own<=none and burst_cnt<=0.
//    Normal rotation then resumes from ptr in that same cycle.
//  - No request: ptr, lock_own and burst_cnt are unchanged, except lock release when the owner's req=0.
//  - Reset mid-operation: in-flight rvalid is dropped, mem_read/mem_write are forced to 0 at the reset
//    edge, and gnt=0 while rst=1. A write already on the bus still commits at the following negedge
//    (memory is unreset); the accepted side considers it done.
//  - X-safety: addr, wdata and we are ignored when req=0.
// STRUCTURE
//  - Package dmem_pkg: ADDR_W=6, DATA_W=32, MEM_DEPTH=64, MAX_REQ=4.
//  - Sub-module rr_pick (combinational): inputs req vector and ptr; output one-hot grant vector,
//    first set bit at or after ptr with wrap.
//  - Top level holds ptr, the lock FSM (states IDLE/LOCKED with burst_cnt), command registers and the read tag.
// TESTING (instantiate with the data memory model, NUM_REQ=2, MAX_BURST=4)
//  - Reset: hold rst 3 cycles with req=2'b11 -> gnt=0, mem_read=mem_write=0, rvalid=0 throughout.
//  - Write then read: r0 writes 0xDEADBEEF at addr 5 and is accepted at E0; r0 reads addr 5 at E1
//    -> rvalid=2'b01 in the cycle after E2, rdata=0xDEADBEEF.
//  - Contention: req=2'b11, both reads, lock=0, 6 cycles -> gnt sequence 01,10,01,10,01,10;
//    rvalid follows the same pattern 2 cycles later.
//  - Burst cap: r1 lock=1 and req=1 continuously, r0 req=1 -> r1 granted exactly 4 consecutive times,
//    then r0, then r1 again.
//  - Early unlock: r1 locks, then drops req after 2 grants -> r0 is granted the very next cycle; burst_cnt=0.
//  - Reset mid-flight: r0 read accepted, rst asserted at the next edge -> no rvalid pulse appears;
//    after reset, ptr=0 and r0 wins the first contention.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Memory geometry, requester limit and lock-state encoding.
package dmem_pkg;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 64;
    localparam int MAX_REQ   = 4;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } lock_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Rotating priority picker.
// Returns a one-hot grant: first set request at or after ptr, with wrap.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_pick;
    logic [2*N-1:0] w_back;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit,
    // then rotate the winner back to its real position.
    assign w_dbl  = {i_req, i_req} >> i_ptr;
    assign w_rot  = w_dbl[N-1:0];
    assign w_pick = w_rot & (~w_rot + N'(1));
    assign w_back = {w_pick, w_pick} << i_ptr;
    assign o_gnt  = w_back[2*N-1:N];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared single-port data memory.
// Registered command bus, tagged read return, bounded burst lock.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_we,
    input  logic [NUM_REQ-1:0]        i_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    output logic                      o_mem_read,
    output logic                      o_mem_write,
    input  logic [DATA_W-1:0]         i_mem_rdata
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    lock_state_e        r_state;
    lock_state_e        w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   r_own;
    logic [PTR_W-1:0]   w_own_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [NUM_REQ-1:0] w_own_hot;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_lock_hit;
    logic               w_any;
    logic [PTR_W-1:0]   w_gidx;
    logic [PTR_W-1:0]   w_gidx_inc;
    logic [CNT_W-1:0]   w_cnt_eff;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_sel_we;

    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [NUM_REQ-1:0] r_tag;
    logic [NUM_REQ-1:0] r_rvalid;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt)
    );

    // A live lock owner that still requests bypasses the rotation.
    assign w_lock_hit = (r_state == ST_LOCKED) && i_req[r_own];
    assign w_own_hot  = NUM_REQ'(1) << r_own;
    assign w_gnt      = i_rst      ? '0        :
                        w_lock_hit ? w_own_hot : w_rr_gnt;
    assign w_any      = |w_gnt;

    // Encode the one-hot grant to an index.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_gidx = PTR_W'(i);
        end
    end

    assign w_gidx_inc  = (w_gidx == PTR_W'(NUM_REQ - 1)) ?
                         '0 : w_gidx + PTR_W'(1);
    assign w_sel_addr  = i_addr[w_gidx*ADDR_W +: ADDR_W];
    assign w_sel_wdata = i_wdata[w_gidx*DATA_W +: DATA_W];
    assign w_sel_we    = i_we[w_gidx];

    // A grant to anyone but a continuing owner starts a fresh burst.
    assign w_cnt_eff = w_lock_hit ? r_cnt : '0;

    // Lock FSM and pointer: next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_own_nxt   = r_own;
        w_cnt_nxt   = r_cnt;
        if (w_any) begin
            if (i_lock[w_gidx] &&
                (w_cnt_eff < CNT_W'(MAX_BURST - 1))) begin
                w_state_nxt = ST_LOCKED;
                w_own_nxt   = w_gidx;
                w_cnt_nxt   = w_cnt_eff + CNT_W'(1);
            end else begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_ptr_nxt   = w_gidx_inc;
            end
        end else if (r_state == ST_LOCKED && !i_req[r_own]) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    // Lock FSM and pointer: state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_own   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_own   <= w_own_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Command stage: launch the granted access and tag it if a read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_tag       <= '0;
        end else if (w_any) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_read  <= ~w_sel_we;
            r_mem_write <= w_sel_we;
            r_tag       <= w_gnt & ~i_we;
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_tag       <= '0;
        end
    end

    // Return stage: memory data arrives now, strobe the issuer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= r_tag;
        end
    end

    assign o_gnt       = w_gnt;
    assign o_rvalid    = r_rvalid;
    assign o_rdata     = i_mem_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a 64x32 memory model.
// Behavioural reference checked every cycle, plus directed literals.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int N  = 2;
    localparam int MB = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req;
    logic [N-1:0]          we;
    logic [N-1:0]          lock;
    logic [N*ADDR_W-1:0]   addr;
    logic [N*DATA_W-1:0]   wdata;
    logic [N-1:0]          gnt;
    logic [N-1:0]          rvalid;
    logic [DATA_W-1:0]     rdata;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W-1:0]     mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_we        (we),
        .i_lock      (lock),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .i_mem_rdata (mem_rdata)
    );

    // Data memory: write on negedge, registered read on posedge.
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    always @(negedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
    always @(posedge clk) if (mem_read)  mem_rdata <= mem[mem_addr];

    // Reference model state.
    logic [DATA_W-1:0] mm [MEM_DEPTH];
    int                m_ptr, m_own, m_streak;
    logic              e_rd, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [N-1:0]      e_tag, e_rv;
    logic [DATA_W-1:0] e_tagdata, e_rdata;
    logic [N-1:0]      last_g;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic step(input logic r, input logic [N-1:0] q,
                        input logic [N-1:0] w, input logic [N-1:0] l,
                        input logic [N*ADDR_W-1:0] a,
                        input logic [N*DATA_W-1:0] d);
        int g;
        int n;
        logic [N-1:0] eg;
        logic [ADDR_W-1:0] ga;
        rst = r; req = q; we = w; lock = l; addr = a; wdata = d;
        #1;
        g = -1;
        if (!r) begin
            if (m_own >= 0 && q[m_own]) g = m_own;
            else begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && q[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        last_g = gnt;
        chk("gnt", gnt, eg);
        if (r) begin
            m_ptr = 0; m_own = -1; m_streak = 0;
            e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
            e_tag = '0; e_rv = '0;
        end else begin
            e_rv = e_tag;
            e_rdata = e_tagdata;
            e_tag = '0;
            if (g >= 0) begin
                ga = a[g*ADDR_W +: ADDR_W];
                e_addr = ga;
                e_wdata = d[g*DATA_W +: DATA_W];
                e_rd = !w[g];
                e_wr = w[g];
                if (w[g]) mm[ga] = d[g*DATA_W +: DATA_W];
                else begin
                    e_tag[g] = 1'b1;
                    e_tagdata = mm[ga];
                end
                n = (g == m_own) ? m_streak + 1 : 1;
                if (l[g] && n < MB) begin
                    m_own = g; m_streak = n;
                end else begin
                    m_own = -1; m_streak = 0; m_ptr = (g + 1) % N;
                end
            end else begin
                e_rd = 0; e_wr = 0;
                if (m_own >= 0 && !q[m_own]) begin
                    m_own = -1; m_streak = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("mem_read", mem_read, e_rd);
        chk("mem_write", mem_write, e_wr);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("rvalid", rvalid, e_rv);
        if (e_rv != '0) chk("rdata", rdata, e_rdata);
    endtask

    task automatic rd(input logic [N-1:0] q, input logic [N-1:0] l);
        step(1'b0, q, '0, l, {6'd9, 6'd3}, {32'h1111, 32'h2222});
    endtask

    task automatic do_reset(input int cyc);
        for (int i = 0; i < cyc; i++)
            step(1'b1, '0, '0, '0, '0, '0);
    endtask

    logic [N-1:0] con_seq [6]  = '{2'b01, 2'b10, 2'b01,
                                   2'b10, 2'b01, 2'b10};
    logic [N-1:0] bur_seq [7]  = '{2'b01, 2'b10, 2'b10, 2'b10,
                                   2'b10, 2'b01, 2'b10};
    logic [N-1:0] unl_seq [8]  = '{2'b10, 2'b10, 2'b01, 2'b10,
                                   2'b10, 2'b10, 2'b10, 2'b01};

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] = 32'hA5A50000 ^ (i * 32'h01010101);
            mm[i]  = 32'hA5A50000 ^ (i * 32'h01010101);
        end
        mem_rdata = '0;
        e_tagdata = '0; e_rdata = '0;
        rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        @(negedge clk);

        // Reset held with both requesting.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b11, 2'b00, 2'b00, '0, '0);
            chk("rst_gnt", last_g, 2'b00);
            chk("rst_rd", mem_read, 1'b0);
            chk("rst_rv", rvalid, 2'b00);
        end

        // Write then read the same address back-to-back.
        step(1'b0, 2'b01, 2'b01, 2'b00, {6'd0, 6'd5},
             {32'h0, 32'hDEADBEEF});
        chk("wr_gnt", last_g, 2'b01);
        step(1'b0, 2'b01, 2'b00, 2'b00, {6'd0, 6'd5}, '0);
        chk("rd_gnt", last_g, 2'b01);
        step(1'b0, 2'b00, 2'b00, 2'b00, '0, '0);
        chk("wr_rd_rv", rvalid, 2'b01);
        chk("wr_rd_data", rdata, 32'hDEADBEEF);

        // Contention, no locking.
        do_reset(2);
        for (int k = 0; k < 7; k++) begin
            if (k < 6) rd(2'b11, 2'b00);
            else rd(2'b00, 2'b00);
            if (k < 6) chk("con_gnt", last_g, con_seq[k]);
            if (k > 0) chk("con_rv", rvalid, con_seq[k-1]);
        end

        // Burst cap with r1 permanently locking.
        do_reset(2);
        for (int k = 0; k < 7; k++) begin
            rd(2'b11, 2'b10);
            chk("burst_gnt", last_g, bur_seq[k]);
        end

        // Early unlock after two locked grants.
        do_reset(2);
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      rd(2'b10, 2'b10);
            else if (k == 2) rd(2'b01, 2'b00);
            else             rd(2'b11, 2'b10);
            chk("unlock_gnt", last_g, unl_seq[k]);
        end

        // Reset while a read is in flight.
        do_reset(2);
        rd(2'b01, 2'b00);
        step(1'b1, 2'b00, 2'b00, 2'b00, '0, '0);
        chk("midrst_rv0", rvalid, 2'b00);
        rd(2'b00, 2'b00);
        chk("midrst_rv1", rvalid, 2'b00);
        rd(2'b11, 2'b00);
        chk("midrst_gnt", last_g, 2'b01);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) == 0),
                 N'($urandom), N'($urandom), N'($urandom),
                 {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))},
                 {32'($urandom), 32'($urandom)});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
